// File: rtl/booth_mul32_seq.sv
// booth_mul32_seq -- sequential radix-2 Booth signed 32x32->64 multiplier, one add/sub per clock (rev 1.0)
`default_nettype none

module adder_subtracter32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        c_in,
  output logic [31:0] r,
  output logic        v
);
  logic [31:0] w_y_eff;

  // c_in=1 selects x - y as x + ~y + 1
  assign w_y_eff = y ^ {32{c_in}};
  assign r       = x + w_y_eff + {31'd0, c_in};
  assign v       = (x[31] == w_y_eff[31]) & (r[31] != x[31]);
endmodule

module booth_mul32_seq #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovf32
);
  localparam logic [4:0] C_LAST = 5'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [WIDTH-1:0]   r_a, r_q, r_m;
  logic               r_q_1;
  logic [4:0]         r_count;

  logic               w_sub, w_use_sum, w_s, w_v, w_last, w_accept;
  logic [WIDTH-1:0]   w_r, w_a_sel, w_a_next, w_q_next;
  logic [2*WIDTH-1:0] w_prod_next;

  assign w_sub     = r_q[0] & ~r_q_1;
  assign w_use_sum = r_q[0] ^ r_q_1;

  adder_subtracter32 u_addsub (
    .x    (r_a),
    .y    (r_m),
    .c_in (w_sub),
    .r    (w_r),
    .v    (w_v)
  );

  // r[31]^v recovers the true sign when A-M or A+M overflows 32 bits
  assign w_a_sel     = w_use_sum ? w_r : r_a;
  assign w_s         = w_use_sum ? (w_r[WIDTH-1] ^ w_v) : r_a[WIDTH-1];
  assign w_a_next    = {w_s, w_a_sel[WIDTH-1:1]};
  assign w_q_next    = {w_a_sel[0], r_q[WIDTH-1:1]};
  assign w_prod_next = {w_a_next, w_q_next};
  assign w_last      = (r_count == C_LAST);
  assign w_accept    = start & (r_state != S_RUN);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = start ? S_RUN : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_q     <= '0;
      r_q_1   <= 1'b0;
      r_m     <= '0;
      r_count <= '0;
      product <= '0;
      ovf32   <= 1'b0;
    end else if (w_accept) begin
      r_m     <= multiplicand;
      r_q     <= multiplier;
      r_a     <= '0;
      r_q_1   <= 1'b0;
      r_count <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= w_a_next;
      r_q     <= w_q_next;
      r_q_1   <= r_q[0];
      r_count <= r_count + 5'd1;
      if (w_last) begin
        product <= w_prod_next;
        ovf32   <= ~((&w_prod_next[2*WIDTH-1:WIDTH-1]) | ~(|w_prod_next[2*WIDTH-1:WIDTH-1]));
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_booth_mul32_seq.sv
// tb_booth_mul32_seq -- directed and randomized checks of booth_mul32_seq against an arithmetic model
`default_nettype none

module tb_booth_mul32_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand, multiplier;
  logic        busy, done, ovf32;
  logic [63:0] product;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // model: cycle position since accept (0 idle, 1..32 run, 33 done)
  int          mdl_cnt = 0;
  logic [31:0] mdl_m, mdl_q;
  logic [63:0] mdl_prod = '0;
  logic        mdl_ovf  = 1'b0;
  logic        mdl_busy = 1'b0;
  logic        mdl_done = 1'b0;

  booth_mul32_seq #(.WIDTH(32), .ITER(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .ovf32        (ovf32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    longint p;
    if (rst) begin
      mdl_cnt  = 0;
      mdl_prod = '0;
      mdl_ovf  = 1'b0;
    end else if (mdl_cnt == 0 || mdl_cnt == 33) begin
      if (start) begin
        mdl_cnt = 1;
        mdl_m   = multiplicand;
        mdl_q   = multiplier;
      end else begin
        mdl_cnt = 0;
      end
    end else begin
      mdl_cnt = mdl_cnt + 1;
      if (mdl_cnt == 33) begin
        p        = longint'($signed(mdl_m)) * longint'($signed(mdl_q));
        mdl_prod = p;
        mdl_ovf  = (p > 64'sh7FFF_FFFF) || (p < -64'sh8000_0000);
      end
    end
    mdl_busy = (mdl_cnt >= 1) && (mdl_cnt <= 32);
    mdl_done = (mdl_cnt == 33);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (busy !== mdl_busy || done !== mdl_done || product !== mdl_prod || ovf32 !== mdl_ovf) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t got/expected: busy=%b/%b done=%b/%b product=%h/%h ovf32=%b/%b",
                 $time, busy, mdl_busy, done, mdl_done, product, mdl_prod, ovf32, mdl_ovf);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] m, input logic [31:0] q);
    @(negedge clk);
    start = 1'b1; multiplicand = m; multiplier = q;
    @(posedge clk);
    #1 start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
  endtask

  // Waits up to 40 cycles after an accept edge; optionally pulses start (9,9) at cycle pulse_at.
  task automatic wait_done(input int pulse_at, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) check("busy_after_accept", {63'd0, busy}, 64'd1);
      if (i == pulse_at) begin start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9; end
      if (i == pulse_at + 1) start = 1'b0;
      if (i == 16 && pulse_at < 0) check("product_hold", product, 64'd6);
      if (done === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic run_dir(input string name, input logic [31:0] m, input logic [31:0] q,
                         input logic [63:0] ep, input logic eo);
    int n;
    issue(m, q);
    wait_done(0, n);
    check({name, "_latency"}, 64'(n), 64'd33);
    check({name, "_product"}, product, ep);
    check({name, "_ovf32"}, {63'd0, ovf32}, {63'd0, eo});
    @(negedge clk);
    check({name, "_done_width"}, {63'd0, done}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    bit seen;
    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_product", product, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);

    run_dir("m3_q5",    32'd3,          32'd5,          64'h0000_0000_0000_000F, 1'b0);
    run_dir("mneg3_q7", 32'hFFFF_FFFD,  32'd7,          64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run_dir("min_min",  32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 1'b1);
    run_dir("max_neg1", 32'h7FFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFF_8000_0001, 1'b0);

    // handshake: ignored start during RUN, back-to-back start in DONE
    issue(32'd2, 32'd3);
    wait_done(5, n);
    check("hs_first_latency", 64'(n), 64'd33);
    check("hs_first_product", product, 64'd6);
    start = 1'b1; multiplicand = 32'd4; multiplier = 32'hFFFF_FFFC;
    @(posedge clk);
    #1 start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
    wait_done(-1, n);
    check("hs_b2b_latency", 64'(n), 64'd33);
    check("hs_b2b_product", product, 64'hFFFF_FFFF_FFFF_FFF0);

    // reset at RUN cycle 10 aborts without a done pulse
    issue(32'd100, 32'd100);
    for (int i = 1; i <= 10; i++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy_done", {62'd0, busy, done}, 64'd0);
    check("abort_product", product, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", {63'd0, seen}, 64'd0);
    run_dir("m100_q100", 32'd100, 32'd100, 64'h0000_0000_0000_2710, 1'b0);

    // randomized traffic, including back-to-back, ignored starts and rare resets
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      start        = ($urandom_range(0, 3) == 0);
      multiplicand = pick();
      multiplier   = pick();
      rst          = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/booth_mul32_seq.md
Name: booth_mul32_seq

Overview:
- Sequential signed 32x32 -> 64-bit multiplier using radix-2 Booth.
- Sequences a single internal adder_subtracter32 instance (ports x, y, c_in, r, v) over 32 iterations, one add/subtract per clock.
- Provides the multiply operation for the datapath without a dedicated array multiplier.
- Start/busy/done handshake toward the issuing unit.

Parameters:
- WIDTH, 32, operand width. Fixed: must equal the adder_subtracter32 width. No other value is supported.
- ITER, 32, number of Booth iterations. Must equal WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Accepted only when busy=0.
- multiplicand  input  32  signed operand M. Sampled on the accept cycle only.
- multiplier  input  32  signed operand Q. Sampled on the accept cycle only.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; product is valid in that cycle.
- product  output  64  signed result {A,Q}.
- ovf32  output  1  high when product is not representable as a signed 32-bit value, i.e. bits [63:31] are not all equal.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - busy=0, done=0, product=0, ovf32=0.
  - Internal A, Q, q_1, M and count are all cleared.
  - Reset overrides start and aborts any operation in progress, with no done pulse.
- States are IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1: load M<=multiplicand, Q<=multiplier, A<=0, q_1<=0, count<=0, then go to RUN.
- RUN:
  - busy=1.
  - Adder is driven with x=A, y=M, c_in=1 when {Q[0],q_1}=10 (A-M), else c_in=0.
  - The sum is used only when {Q[0],q_1} is 01 (A+M) or 10 (A-M). For 00 and 11, A' = A.
  - True sign bit s = r[31] XOR v on add/sub cycles, and s = A[31] on hold cycles.
  - Arithmetic right shift: {A,Q,q_1} <= {s, A'[31:0], Q} >> 0, i.e. A<={s,A'[31:1]}, Q<={A'[0],Q[31:1]}, q_1<=Q[0].
  - The v correction is mandatory. It covers M=0x80000000, where A-M overflows 32 bits.
  - count increments each cycle. After the 32nd RUN cycle (count==31), go to DONE.
  - start is ignored in RUN.
- DONE (exactly 1 cycle):
  - done=1, busy=0.
  - product and ovf32 are registered on entry to DONE and are valid in this cycle.
  - If start=1 in DONE, it is accepted and operands are loaded exactly as in IDLE, with next state RUN (back-to-back). Otherwise go to IDLE.
- Output stability: product and ovf32 hold their value until the next DONE or reset. They are not cleared by a new start.
- Latency:
  - start accepted at edge E0.
  - RUN occupies cycles 1..32.
  - done is high in cycle 33 after acceptance.
  - Back-to-back issue gives a throughput of one result per 33 cycles.
- Operands changing while busy=1 have no effect.

Test Plan:
- rst 2 cycles, then start with M=3, Q=5 -> busy rises the next cycle; done high for exactly 1 cycle, 33 cycles after accept; product=0x00000000_0000000F, ovf32=0.
- M=0xFFFFFFFD (-3), Q=7 -> product=0xFFFFFFFF_FFFFFFEB (-21), ovf32=0.
- M=0x80000000, Q=0x80000000 -> product=0x40000000_00000000, ovf32=1. This exercises the r[31]^v sign correction.
- M=0x7FFFFFFF, Q=0xFFFFFFFF -> product=0xFFFFFFFF_80000001, ovf32=0.
- Handshake:
  - Issue M=2, Q=3.
  - Pulse start with M=9, Q=9 during RUN -> ignored; result is 6.
  - Assert start with M=4, Q=-4 in the DONE cycle -> accepted with no IDLE gap; next done exactly 33 cycles later with product=0xFFFFFFFF_FFFFFFF0.
  - Between the two results, product holds 6.
- Reset mid-operation:
  - Issue M=100, Q=100.
  - Assert rst at RUN cycle 10 -> next cycle busy=0, done=0, product=0, and no done pulse follows.
  - A subsequent start with M=100, Q=100 -> product=0x00000000_00002710.
